// File: rtl/grid_select_ctrl.sv
// Button-driven cursor/lock controller for a 3x3 grid; writes the 18-bit
// grid_data word read by the OLED grid renderer and emits confirm events.
module grid_select_ctrl #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [23:0] BLINK_CYCLES    = 24'd6250000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        clear,
   input  logic        btnU,
   input  logic        btnD,
   input  logic        btnL,
   input  logic        btnR,
   input  logic        btnC,
   output logic [17:0] grid_data,
   output logic [3:0]  cursor_idx,
   output logic        confirm_valid,
   output logic [3:0]  confirm_idx,
   output logic        reject,
   output logic        full
);
   localparam int NB  = 5;
   localparam int B_R = 0;
   localparam int B_L = 1;
   localparam int B_D = 2;
   localparam int B_U = 3;
   localparam int B_C = 4;

   typedef enum logic [1:0] {IDLE, SELECT, FULL} state_t;

   logic [NB-1:0] raw, sync1_q, sync2_q;
   logic [NB-1:0] db_q, db_d, arm_q, arm_d, press_q, press_d;
   logic [15:0]   cnt_q [NB];
   logic [15:0]   cnt_d [NB];

   state_t      state_q;
   logic [8:0]  lock_q;
   logic [8:0]  lock_set;
   logic        move_ev;
   logic        blink_on_q;
   logic [23:0] blink_cnt_q;
   logic [3:0]  cursor_q, confirm_idx_q;
   logic [17:0] grid_q;
   logic        confirm_q, reject_q, full_q;

   assign raw = {btnC, btnU, btnD, btnL, btnR};

   // Synchronizers carry no reset so a held button stays visible through reset.
   always_ff @(posedge clk) begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
   end

   // A button must be seen released before its first press is honoured.
   always_comb begin
      for (int i = 0; i < NB; i++) begin
         db_d[i]    = db_q[i];
         cnt_d[i]   = 16'd0;
         press_d[i] = 1'b0;
         arm_d[i]   = arm_q[i] | ~sync2_q[i];
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
               db_d[i]    = sync2_q[i];
               press_d[i] = sync2_q[i] & arm_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         db_q    <= '0;
         arm_q   <= '0;
         press_q <= '0;
         for (int i = 0; i < NB; i++) cnt_q[i] <= 16'd0;
      end else begin
         db_q    <= db_d;
         arm_q   <= arm_d;
         press_q <= press_d;
         for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   function automatic logic [3:0] move(input logic [3:0] idx, input logic [NB-1:0] ev);
      logic [3:0] col;
      col = (idx >= 4'd6) ? idx - 4'd6 : (idx >= 4'd3) ? idx - 4'd3 : idx;
      if (ev[B_U])      move = (idx >= 4'd3) ? idx - 4'd3 : idx + 4'd6;
      else if (ev[B_D]) move = (idx <  4'd6) ? idx + 4'd3 : idx - 4'd6;
      else if (ev[B_L]) move = (col == 4'd0) ? idx + 4'd2 : idx - 4'd1;
      else if (ev[B_R]) move = (col == 4'd2) ? idx - 4'd2 : idx + 4'd1;
      else              move = idx;
   endfunction

   function automatic logic [17:0] render(input state_t st, input logic [3:0] cur,
                                          input logic [8:0] lk, input logic bl);
      render = '0;
      for (int k = 0; k < 9; k++) begin
         if (lk[k])                                 render[2*k +: 2] = 2'b10;
         else if (st == SELECT && cur == 4'(k))     render[2*k +: 2] = bl ? 2'b11 : 2'b01;
      end
   endfunction

   assign lock_set = lock_q | (9'd1 << cursor_q);
   assign move_ev  = |press_q[B_U:B_R];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         lock_q        <= '0;
         cursor_q      <= 4'd4;
         confirm_q     <= 1'b0;
         confirm_idx_q <= 4'd0;
         reject_q      <= 1'b0;
         full_q        <= 1'b0;
         blink_on_q    <= 1'b1;
         blink_cnt_q   <= '0;
         grid_q        <= '0;
      end else begin
         confirm_q <= 1'b0;
         reject_q  <= 1'b0;
         grid_q    <= render(state_q, cursor_q, lock_q, blink_on_q);
         if (clear) begin
            lock_q      <= '0;
            cursor_q    <= 4'd4;
            full_q      <= 1'b0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            state_q     <= enable ? SELECT : IDLE;
         end else begin
            unique case (state_q)
               IDLE: if (enable) state_q <= full_q ? FULL : SELECT;
               SELECT: begin
                  if (!enable) begin
                     state_q <= IDLE;
                  end else begin
                     if (blink_cnt_q == BLINK_CYCLES - 24'd1) begin
                        blink_cnt_q <= '0;
                        blink_on_q  <= ~blink_on_q;
                     end else begin
                        blink_cnt_q <= blink_cnt_q + 24'd1;
                     end
                     if (press_q[B_C]) begin
                        if (lock_set == lock_q) begin
                           reject_q <= 1'b1;
                        end else begin
                           lock_q        <= lock_set;
                           confirm_q     <= 1'b1;
                           confirm_idx_q <= cursor_q;
                           if (&lock_set) begin
                              full_q  <= 1'b1;
                              state_q <= FULL;
                           end
                        end
                     end else if (move_ev) begin
                        cursor_q    <= move(cursor_q, press_q);
                        blink_cnt_q <= '0;
                        blink_on_q  <= 1'b1;
                     end
                  end
               end
               FULL:    state_q <= FULL;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign grid_data     = grid_q;
   assign cursor_idx    = cursor_q;
   assign confirm_valid = confirm_q;
   assign confirm_idx   = confirm_idx_q;
   assign reject        = reject_q;
   assign full          = full_q;
endmodule

// File: tb/tb_grid_select_ctrl.sv
// Directed bench for grid_select_ctrl with short debounce/blink periods.
module tb_grid_select_ctrl;
   logic        clk = 1'b0;
   logic        reset, enable, clear;
   logic        btnU, btnD, btnL, btnR, btnC;
   logic [17:0] grid_data;
   logic [3:0]  cursor_idx, confirm_idx;
   logic        confirm_valid, reject, full;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [4:0] M_R = 5'b00001;
   localparam logic [4:0] M_L = 5'b00010;
   localparam logic [4:0] M_D = 5'b00100;
   localparam logic [4:0] M_U = 5'b01000;
   localparam logic [4:0] M_C = 5'b10000;

   grid_select_ctrl #(
      .DEBOUNCE_CYCLES(16'd4),
      .BLINK_CYCLES   (24'd8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .clear        (clear),
      .btnU         (btnU),
      .btnD         (btnD),
      .btnL         (btnL),
      .btnR         (btnR),
      .btnC         (btnC),
      .grid_data    (grid_data),
      .cursor_idx   (cursor_idx),
      .confirm_valid(confirm_valid),
      .confirm_idx  (confirm_idx),
      .reject       (reject),
      .full         (full)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_btn(input logic [4:0] m);
      {btnC, btnU, btnD, btnL, btnR} = m;
   endtask

   // Press, hold until the action lands (7 edges), then release and let it settle.
   task automatic do_press(input logic [4:0] m);
      set_btn(m);
      step(7);
      set_btn(5'b0);
      step(8);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; clear = 1'b0;
      set_btn(5'b0);
      step(3);
      check("rst_grid",   32'(grid_data), 32'h0);
      check("rst_cursor", 32'(cursor_idx), 32'd4);
      check("rst_cv",     32'(confirm_valid), 32'd0);
      check("rst_cidx",   32'(confirm_idx), 32'd0);
      check("rst_reject", 32'(reject), 32'd0);
      check("rst_full",   32'(full), 32'd0);

      reset = 1'b0; enable = 1'b1;
      step(1);
      check("en_grid_e1", 32'(grid_data), 32'h0);
      step(1);
      check("en_grid_e2", 32'(grid_data), 32'h00300);
      step(7);
      check("blink_on_last", 32'(grid_data), 32'h00300);
      step(1);
      check("blink_off", 32'(grid_data), 32'h00100);
      step(7);
      check("blink_off_last", 32'(grid_data), 32'h00100);
      step(1);
      check("blink_on_again", 32'(grid_data), 32'h00300);

      do_press(M_R);
      check("move_r_5", 32'(cursor_idx), 32'd5);
      set_btn(M_R);
      step(20);
      check("hold_r_wrap", 32'(cursor_idx), 32'd3);
      set_btn(5'b0);
      step(8);
      check("hold_r_once", 32'(cursor_idx), 32'd3);
      check("grid_cur3", 32'(grid_data & ~18'h00080), 32'h00040);

      do_press(M_U);
      check("move_u_0", 32'(cursor_idx), 32'd0);
      set_btn(M_L);
      step(3);
      set_btn(5'b0);
      step(10);
      check("glitch_l", 32'(cursor_idx), 32'd0);

      set_btn(M_C);
      step(7);
      check("c0_cv", 32'(confirm_valid), 32'd1);
      check("c0_idx", 32'(confirm_idx), 32'd0);
      check("c0_rej", 32'(reject), 32'd0);
      step(1);
      check("c0_cv_end", 32'(confirm_valid), 32'd0);
      check("c0_grid", 32'(grid_data[1:0]), 32'd2);
      set_btn(5'b0);
      step(8);

      set_btn(M_C);
      step(7);
      check("c0_again_rej", 32'(reject), 32'd1);
      check("c0_again_cv", 32'(confirm_valid), 32'd0);
      step(1);
      check("c0_again_rej_end", 32'(reject), 32'd0);
      set_btn(5'b0);
      step(8);

      do_press(M_R);
      check("move_r_1", 32'(cursor_idx), 32'd1);
      set_btn(M_C | M_R);
      step(7);
      check("cr_cv", 32'(confirm_valid), 32'd1);
      check("cr_idx", 32'(confirm_idx), 32'd1);
      check("cr_cursor", 32'(cursor_idx), 32'd1);
      set_btn(5'b0);
      step(8);
      check("cr_grid", 32'(grid_data & 18'h0000F), 32'hA);

      do_press(M_R);
      check("move_r_2", 32'(cursor_idx), 32'd2);
      set_btn(M_C);
      step(6);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      check("clrc_cv", 32'(confirm_valid), 32'd0);
      check("clrc_cursor", 32'(cursor_idx), 32'd4);
      step(1);
      check("clrc_grid", 32'(grid_data), 32'h00300);
      set_btn(5'b0);
      step(8);

      do_press(M_C);
      do_press(M_R);
      do_press(M_C);
      do_press(M_R);
      check("fill_cur3", 32'(cursor_idx), 32'd3);
      do_press(M_C);
      do_press(M_U);
      do_press(M_C);
      do_press(M_R);
      do_press(M_C);
      do_press(M_R);
      do_press(M_C);
      do_press(M_U);
      check("fill_cur8", 32'(cursor_idx), 32'd8);
      do_press(M_C);
      do_press(M_L);
      do_press(M_C);
      do_press(M_L);
      check("fill_cur6", 32'(cursor_idx), 32'd6);
      check("fill_full_pre", 32'(full), 32'd0);
      set_btn(M_C);
      step(7);
      check("ninth_cv", 32'(confirm_valid), 32'd1);
      check("ninth_idx", 32'(confirm_idx), 32'd6);
      check("ninth_full", 32'(full), 32'd1);
      step(1);
      check("full_grid", 32'(grid_data), 32'h2AAAA);
      set_btn(5'b0);
      step(8);
      do_press(M_R);
      check("full_ignore_cur", 32'(cursor_idx), 32'd6);
      check("full_ignore_grid", 32'(grid_data), 32'h2AAAA);

      clear = 1'b1;
      step(1);
      clear = 1'b0;
      check("clr_full", 32'(full), 32'd0);
      check("clr_cursor", 32'(cursor_idx), 32'd4);
      step(1);
      check("clr_grid", 32'(grid_data), 32'h00300);

      do_press(M_R);
      do_press(M_C);
      do_press(M_L);
      check("pre_dis_cur", 32'(cursor_idx), 32'd4);
      enable = 1'b0;
      step(2);
      check("dis_grid", 32'(grid_data), 32'h00800);
      do_press(M_R);
      check("dis_cursor", 32'(cursor_idx), 32'd4);
      check("dis_grid2", 32'(grid_data), 32'h00800);

      enable = 1'b1;
      set_btn(M_D);
      step(3);
      reset = 1'b1;
      step(2);
      check("midrst_grid", 32'(grid_data), 32'h0);
      check("midrst_cursor", 32'(cursor_idx), 32'd4);
      reset = 1'b0;
      step(20);
      check("held_d_cursor", 32'(cursor_idx), 32'd4);
      check("held_d_grid", 32'(grid_data & 18'h3FCFF), 32'h0);
      set_btn(5'b0);
      step(8);
      do_press(M_D);
      check("repress_d", 32'(cursor_idx), 32'd7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
